iterative_cla_adder: RTL and testbench

ITERATIVE_CLA_ADDER -- requirements
Module: iterative_cla_adder

---
 rtl/iterative_cla_adder.sv | 127 ++++++++++++
 tb/tb_iterative_cla_adder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_cla_adder.sv
// Multi-cycle adder/subtractor: one BLOCK-bit carry-lookahead slice per clock,
// results published all at once when the last slice completes.
module iterative_cla_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    // WIDTH must be a multiple of BLOCK with at least two slices.
    localparam int NBLK = WIDTH / BLOCK;
    localparam int KW   = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NBLK - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, acc_reg, sum_reg;
    logic             carry_reg, cout_reg, ovf_reg, zero_reg;
    logic [KW-1:0]    k_reg;

    logic [BLOCK-1:0] slice_a, slice_b, gen, prop, slice_sum;
    logic [BLOCK:0]   carry;
    logic [WIDTH-1:0] acc_next;
    logic             last_slice;

    // Operands are shifted down each cycle so the active slice is always the LSBs.
    assign slice_a = a_reg[BLOCK-1:0];
    assign slice_b = b_reg[BLOCK-1:0];
    assign gen     = slice_a & slice_b;
    assign prop    = slice_a ^ slice_b;
    assign carry[0] = carry_reg;

    // Each group carry is a flat sum-of-products of g/p and the carry-in.
    for (genvar gi = 0; gi < BLOCK; gi++) begin : g_lookahead
        logic carry_term;
        logic chain;
        always_comb begin
            carry_term = carry_reg;
            chain      = 1'b0;
            for (int t = 0; t <= gi; t++) begin
                carry_term = carry_term & prop[t];
            end
            for (int j = 0; j <= gi; j++) begin
                chain = gen[j];
                for (int t = j + 1; t <= gi; t++) begin
                    chain = chain & prop[t];
                end
                carry_term = carry_term | chain;
            end
        end
        assign carry[gi+1] = carry_term;
    end

    assign slice_sum  = prop ^ carry[BLOCK-1:0];
    assign acc_next   = {slice_sum, acc_reg[WIDTH-1:BLOCK]};
    assign last_slice = (k_reg == K_LAST);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_slice) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            carry_reg <= 1'b0;
            k_reg     <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            zero_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= op[0] ? ~b : b;
                        carry_reg <= op[1] ? (cin ^ op[0]) : op[0];
                        k_reg     <= '0;
                    end
                end
                RUN: begin
                    a_reg     <= a_reg >> BLOCK;
                    b_reg     <= b_reg >> BLOCK;
                    acc_reg   <= acc_next;
                    carry_reg <= carry[BLOCK];
                    k_reg     <= k_reg + KW'(1);
                    if (last_slice) begin
                        sum_reg  <= acc_next;
                        cout_reg <= carry[BLOCK];
                        ovf_reg  <= carry[BLOCK] ^ carry[BLOCK-1];
                        zero_reg <= (acc_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;
    assign zero = zero_reg;
endmodule

// File: tb/tb_iterative_cla_adder.sv
// Scoreboard bench for iterative_cla_adder: default 32/4 instance plus a 16/8 instance.
module tb_iterative_cla_adder;
    logic        clk = 1'b0;
    logic        rst, start, cin;
    logic [1:0]  op;
    logic [31:0] a, b, sum;
    logic        busy, done, cout, ovf, zero;

    logic        start16, cin16;
    logic [1:0]  op16;
    logic [15:0] a16, b16, sum16;
    logic        busy16, done16, cout16, ovf16, zero16;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    iterative_cla_adder dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    iterative_cla_adder #(.WIDTH(16), .BLOCK(8)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .op(op16), .a(a16), .b(b16), .cin(cin16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16), .zero(zero16)
    );

    function automatic exp_t model(input logic [1:0] m_op, input logic [31:0] m_a,
                                   input logic [31:0] m_b, input logic m_cin);
        logic [31:0] bb;
        logic        c0;
        logic [32:0] full;
        logic [31:0] low;
        exp_t        e;
        bb = (m_op == 2'b01 || m_op == 2'b11) ? ~m_b : m_b;
        case (m_op)
            2'b00:   c0 = 1'b0;
            2'b01:   c0 = 1'b1;
            2'b10:   c0 = m_cin;
            default: c0 = ~m_cin;
        endcase
        full   = {1'b0, m_a} + {1'b0, bb} + {32'd0, c0};
        low    = {1'b0, m_a[30:0]} + {1'b0, bb[30:0]} + {31'd0, c0};
        e.sum  = full[31:0];
        e.cout = full[32];
        e.ovf  = full[32] ^ low[31];
        e.zero = (full[31:0] == 32'd0);
        return e;
    endfunction

    // Drive a request at a falling edge; returns at the falling edge after acceptance.
    task automatic start_op(input logic [1:0] t_op, input logic [31:0] t_a,
                            input logic [31:0] t_b, input logic t_cin, input bit record);
        if (record) sb.push_back(model(t_op, t_a, t_b, t_cin));
        op = t_op; a = t_a; b = t_b; cin = t_cin; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                cycles = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, done, cout, ovf, zero} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got busy/done/cout/ovf/zero=%b expected 00000", {busy, done, cout, ovf, zero});
        end
        n_checks++;
        if (sum !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_sum: got %h expected 00000000", sum);
        end
        start = 1'b0; rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b expected 0", busy);
        end
        $display("reset: busy=%b done=%b sum=%h", busy, done, sum);
    endtask

    task automatic test_directed();
        logic [1:0]  ops [5] = '{2'b00, 2'b01, 2'b00, 2'b11, 2'b10};
        logic [31:0] as_ [5] = '{32'hFFFFFFFF, 32'd5, 32'h7FFFFFFF, 32'h10, 32'h80000000};
        logic [31:0] bs_ [5] = '{32'h1, 32'd7, 32'h1, 32'h0, 32'h80000000};
        logic        cs_ [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int   cyc;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            start_op(ops[i], as_[i], bs_[i], cs_[i], 1'b1);
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL directed%0d_busy: got %b expected 1", i, busy);
            end
            wait_done(cyc);
            n_checks++;
            if (cyc != 8) begin
                n_fail++;
                $display("FAIL directed%0d_latency: got %0d expected 8", i, cyc);
            end
            e = sb.pop_front();
            n_checks++;
            if ({sum, cout, ovf, zero} !== {e.sum, e.cout, e.ovf, e.zero}) begin
                n_fail++;
                $display("FAIL directed%0d_result: got sum=%h c=%b v=%b z=%b expected sum=%h c=%b v=%b z=%b",
                         i, sum, cout, ovf, zero, e.sum, e.cout, e.ovf, e.zero);
            end
            $display("directed op=%b a=%h b=%h cin=%b -> sum=%h cout=%b ovf=%b zero=%b lat=%0d",
                     ops[i], as_[i], bs_[i], cs_[i], sum, cout, ovf, zero, cyc);
            @(negedge clk);
            n_checks++;
            if ({done, busy} !== 2'b00) begin
                n_fail++;
                $display("FAIL directed%0d_pulse: got done/busy=%b expected 00", i, {done, busy});
            end
        end
        // Spot-check the model against hand-computed values.
        e = model(2'b00, 32'h7FFFFFFF, 32'h1, 1'b0);
        n_checks++;
        if ({e.sum, e.cout, e.ovf} !== {32'h80000000, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL model_ovf: got %h/%b/%b expected 80000000/0/1", e.sum, e.cout, e.ovf);
        end
    endtask

    task automatic test_ignore_and_hold();
        int   cyc;
        exp_t e;
        start_op(2'b00, 32'd1, 32'd1, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        a = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        n_checks++;
        if (cyc != 5) begin
            n_fail++;
            $display("FAIL ignore_latency: got %0d expected 5", cyc);
        end
        e = sb.pop_front();
        n_checks++;
        if (sum !== e.sum) begin
            n_fail++;
            $display("FAIL ignore_sum: got %h expected %h", sum, e.sum);
        end
        a = 32'hDEADBEEF; b = 32'h12345678; op = 2'b11;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({sum, done, busy} !== {32'd2, 2'b00}) begin
            n_fail++;
            $display("FAIL hold: got sum=%h done/busy=%b expected sum=00000002 done/busy=00", sum, {done, busy});
        end
        $display("ignore/hold: sum=%h after stray start", sum);
    endtask

    task automatic test_abort();
        bit saw_done = 1'b0;
        start_op(2'b00, 32'h1234, 32'h4321, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({busy, done, sum, cout, ovf, zero} !== 36'd0) begin
            n_fail++;
            $display("FAIL abort_state: got busy=%b done=%b sum=%h expected 0 0 00000000", busy, done, sum);
        end
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done || sum !== 32'd0) begin
            n_fail++;
            $display("FAIL abort_nodone: got done_seen=%b sum=%h expected 0 00000000", saw_done, sum);
        end
        $display("abort: busy=%b sum=%h done_seen=%b", busy, sum, saw_done);
    endtask

    task automatic test_back_to_back();
        int          cyc;
        exp_t        e;
        logic [1:0]  r_op;
        logic [31:0] r_a, r_b;
        logic        r_c;
        for (int i = 0; i < 8; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            r_b  = (i == 0) ? r_a : $urandom;
            r_c  = 1'($urandom_range(0, 1));
            if (i == 0) r_op = 2'b01;
            start_op(r_op, r_a, r_b, r_c, 1'b1);
            wait_done(cyc);
            n_checks++;
            if (cyc != 8 || sb.size() == 0) begin
                n_fail++;
                $display("FAIL b2b%0d_latency: got %0d expected 8", i, cyc);
            end else begin
                e = sb.pop_front();
                n_checks++;
                if ({sum, cout, ovf, zero} !== {e.sum, e.cout, e.ovf, e.zero}) begin
                    n_fail++;
                    $display("FAIL b2b%0d_result: got sum=%h c=%b v=%b z=%b expected sum=%h c=%b v=%b z=%b",
                             i, sum, cout, ovf, zero, e.sum, e.cout, e.ovf, e.zero);
                end
            end
            $display("b2b op=%b a=%h b=%h cin=%b -> sum=%h cout=%b ovf=%b zero=%b",
                     r_op, r_a, r_b, r_c, sum, cout, ovf, zero);
            @(negedge clk);
        end
    endtask

    task automatic test_wide16();
        logic [1:0]  w_op  [2] = '{2'b10, 2'b01};
        logic [15:0] w_a   [2] = '{16'h00FF, 16'h8000};
        logic [15:0] w_b   [2] = '{16'h0000, 16'h0001};
        logic [15:0] w_sum [2] = '{16'h0100, 16'h7FFF};
        logic [1:0]  w_cv  [2] = '{2'b00, 2'b11};
        int cyc;
        for (int i = 0; i < 2; i++) begin
            op16 = w_op[i]; a16 = w_a[i]; b16 = w_b[i]; cin16 = 1'b1; start16 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start16 = 1'b0;
            cyc = -1;
            for (int n = 1; n <= 20; n++) begin
                @(posedge clk);
                @(negedge clk);
                if (done16 === 1'b1) begin
                    cyc = n;
                    break;
                end
            end
            n_checks++;
            if (cyc != 2) begin
                n_fail++;
                $display("FAIL wide%0d_latency: got %0d expected 2", i, cyc);
            end
            n_checks++;
            if ({sum16, cout16, ovf16} !== {w_sum[i], w_cv[i]}) begin
                n_fail++;
                $display("FAIL wide%0d_result: got sum=%h c=%b v=%b expected sum=%h c/v=%b",
                         i, sum16, cout16, ovf16, w_sum[i], w_cv[i]);
            end
            $display("wide16 op=%b a=%h b=%h -> sum=%h cout=%b ovf=%b lat=%0d",
                     w_op[i], w_a[i], w_b[i], sum16, cout16, ovf16, cyc);
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; cin = 1'b0;
        start16 = 1'b0; op16 = 2'b00; a16 = '0; b16 = '0; cin16 = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_ignore_and_hold();
        test_abort();
        test_back_to_back();
        test_wide16();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
